// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell plus a borrow flop,
// LSB first, one bit per clock, behind a start/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             dbit,
    output logic             dbit_valid,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic [1:0]       dbg_state
);

    // Handshake: start is a request taken only in IDLE or DONE; done is a
    // one-cycle pulse, and diff/borrow stay valid until the next accepted start.
    localparam int CW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bin_q, bin_d;
    logic             borrow_q, borrow_d;

    logic x_bit, y_bit, d_bit, bout;

    // Full-subtractor cell on the current LSBs.
    assign x_bit = opa_q[0];
    assign y_bit = opb_q[0];
    assign d_bit = x_bit ^ y_bit ^ bin_q;
    assign bout  = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & bin_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            borrow_q <= borrow_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        res_d    = res_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        borrow_d = borrow_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_SHIFT;
                    opa_d   = a;
                    opb_d   = b;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                opa_d = {1'b0, opa_q[WIDTH-1:1]};
                opb_d = {1'b0, opb_q[WIDTH-1:1]};
                res_d = {d_bit, res_q[WIDTH-1:1]};
                bin_d = bout;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // The last bit lands in the result on the same edge it is published.
                    state_d  = S_DONE;
                    diff_d   = {d_bit, res_q[WIDTH-1:1]};
                    borrow_d = bout;
                    cnt_d    = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy       = (state_q == S_SHIFT);
    assign dbit_valid = busy;
    assign dbit       = busy & d_bit;
    assign done       = (state_q == S_DONE);
    assign diff       = diff_q;
    assign borrow     = borrow_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8) with hand-computed expected results.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, dbit, dbit_valid, done, borrow;
    logic [W-1:0] diff;
    logic [1:0]   dbg_state;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .dbit       (dbit),
        .dbit_valid (dbit_valid),
        .done       (done),
        .diff       (diff),
        .borrow     (borrow),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation from IDLE or DONE and follows it to its DONE cycle.
    // Leaves start low on return, so the DUT is sitting in DONE.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] ed, input logic eb,
                          output int scyc, output int dcyc);
        start = 1'b1;
        a = av;
        b = bv;
        step();
        start = 1'b0;
        scyc = cyc;
        for (int i = 0; i < W; i++) begin
            check("busy", busy, 1);
            check("dbit_valid", dbit_valid, 1);
            check("dbit", dbit, ed[i]);
            check("done_early", done, 0);
            step();
        end
        dcyc = cyc;
        check("done", done, 1);
        check("diff", diff, ed);
        check("borrow", borrow, eb);
        check("busy_in_done", busy, 0);
        check("dval_in_done", dbit_valid, 0);
    endtask

    initial begin
        int s0, d0, s1, d1, n_done;

        // Reset state
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow, 0);
        check("rst_dbit", dbit, 0);
        check("rst_dval", dbit_valid, 0);
        check("rst_state", dbg_state, 0);
        rst = 1'b0;
        step();

        // 1: 5-3, with latency
        run_op(8'h05, 8'h03, 8'h02, 1'b0, s0, d0);
        check("latency", d0 - s0, W);

        // 6: idle hold after case 1
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_diff", diff, 8'h02);
            check("idle_done", done, 0);
            check("idle_busy", busy, 0);
        end

        // 2: wrap and borrow corners
        run_op(8'h03, 8'h05, 8'hFE, 1'b1, s0, d0);
        step();
        run_op(8'h00, 8'hFF, 8'h01, 1'b1, s0, d0);
        step();
        run_op(8'hFF, 8'hFF, 8'h00, 1'b0, s0, d0);
        step();

        // 3: start during SHIFT is ignored
        start = 1'b1;
        a = 8'h10;
        b = 8'h01;
        step();
        start = 1'b0;
        s0 = cyc;
        step();
        step();
        check("c3_in_shift", busy, 1);
        start = 1'b1;
        a = 8'hAA;
        b = 8'h55;
        step();
        start = 1'b0;
        n_done = 0;
        d0 = 0;
        for (int i = 0; i < 14; i++) begin
            if (done) begin
                n_done++;
                d0 = cyc;
                check("c3_diff", diff, 8'h0F);
                check("c3_borrow", borrow, 0);
            end
            if (cyc - s0 < W - 1) check("c3_diff_held", diff, 8'h00);
            step();
        end
        check("c3_done_count", n_done, 1);
        check("c3_done_cycle", d0 - s0, W);

        // 4: reset aborts an in-flight operation
        start = 1'b1;
        a = 8'h80;
        b = 8'h01;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check("c4_in_shift", busy, 1);
        check("c4_diff_before", diff, 8'h0F);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("c4_busy", busy, 0);
        check("c4_diff", diff, 0);
        check("c4_borrow", borrow, 0);
        check("c4_done", done, 0);
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) n_done++;
            step();
        end
        check("c4_no_done", n_done, 0);
        run_op(8'h09, 8'h04, 8'h05, 1'b0, s0, d0);
        step();

        // 5: back-to-back, second start presented in the DONE cycle
        run_op(8'h20, 8'h10, 8'h10, 1'b0, s0, d0);
        run_op(8'h01, 8'h02, 8'hFF, 1'b1, s1, d1);
        check("b2b_gap", d1 - d0, W + 1);
        step();
        check("b2b_idle_done", done, 0);
        check("b2b_idle_diff", diff, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
